// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key debounce / interrupt controller.
package key_ctrl_pkg;

  // Avalon word addresses of the register map
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  // Per-key debounce state
  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } deb_state_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: two-flop synchroniser, debounce FSM and settle counter.
// db is the debounced level (active-low key, 1 = released); press pulses
// for one cycle on the same edge db falls 1->0.
module key_debounce_cell
  import key_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_raw,
  input  logic [CNT_W-1:0] period,
  output logic             db,
  output logic             press
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  deb_state_t       state, state_nxt;
  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_m1;
  logic             done;
  logic             diff;
  logic             cnt_clr, cnt_inc, db_load;

  // Period 0 is treated as 1; the >= compare lets a shrinking period
  // still terminate a settle already past the new limit.
  assign per_m1 = (period == '0) ? '0 : period - ONE;
  assign done   = (cnt >= per_m1);
  assign diff   = (sync2 != db);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= STABLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      STABLE: if (diff)         state_nxt = SETTLE;
      SETTLE: if (!diff || done) state_nxt = STABLE;
      default:                  state_nxt = STABLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    cnt_clr = (state == STABLE) && diff;
    cnt_inc = (state == SETTLE) && diff && !done;
    db_load = (state == SETTLE) && diff && done;
    press   = db_load && !sync2;
  end

  // Synchroniser, settle counter and debounced level
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + ONE;
      if (db_load)      db  <= sync2;
    end
  end

endmodule

// File: rtl/key_debounce_irq_ctrl.sv
// Avalon-MM push-button controller: per-key debounce, press capture (W1C),
// per-key interrupt mask and a registered level interrupt.
module key_debounce_irq_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int               KEY_W        = 2,
  parameter int               CNT_W        = 16,
  parameter logic [CNT_W-1:0] DEF_DEBOUNCE = 16'd50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [KEY_W-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [KEY_W-1:0] db_lvl;
  logic [KEY_W-1:0] press;
  logic [KEY_W-1:0] mask_q;
  logic [KEY_W-1:0] edge_q;
  logic [CNT_W-1:0] period_q;
  logic [KEY_W-1:0] w1c;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  // Upper writedata bits beyond the implemented register widths are dropped
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect && !write_n;
  assign w1c   = (wr_en && address == ADDR_EDGE) ? writedata[KEY_W-1:0] : '0;

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    key_debounce_cell #(.CNT_W(CNT_W)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .key_raw (in_port[i]),
      .period  (period_q),
      .db      (db_lvl[i]),
      .press   (press[i])
    );
  end

  // MASK and PERIOD registers; DATA is read-only
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= DEF_DEBOUNCE;
    end else if (wr_en) begin
      if (address == ADDR_MASK)   mask_q   <= writedata[KEY_W-1:0];
      if (address == ADDR_PERIOD) period_q <= writedata[CNT_W-1:0];
    end
  end

  // Press capture: a new press wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset_n) edge_q <= '0;
    else          edge_q <= (edge_q & ~w1c) | press;
  end

  // Read mux, zero-extended
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:   rd_mux[KEY_W-1:0] = db_lvl;
      ADDR_MASK:   rd_mux[KEY_W-1:0] = mask_q;
      ADDR_EDGE:   rd_mux[KEY_W-1:0] = edge_q;
      ADDR_PERIOD: rd_mux[CNT_W-1:0] = period_q;
      default:     rd_mux = '0;
    endcase
  end

  // Registered read data and interrupt
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_key_debounce_irq_ctrl.sv
// Directed bench for key_debounce_irq_ctrl (KEY_W=2, CNT_W=16).
// Edge numbering: inputs change just after edge 0; a clean key change is
// then first captured at edge 1 and reaches db at edge 3+PERIOD, which the
// registered readdata shows one edge later.
module tb_key_debounce_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  key_debounce_irq_ctrl #(.KEY_W(2), .CNT_W(16), .DEF_DEBOUNCE(16'd50000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    tick();
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 2'b11;

    // 1. reset values
    repeat (3) tick();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    rd("rst_data", 2'd0, 32'h3);
    rd("rst_period", 2'd3, 32'd50000);
    rd("rst_mask", 2'd1, 32'h0);
    rd("rst_edge", 2'd2, 32'h0);

    // 2. PERIOD width truncation, then PERIOD=4 and a clean press on key0
    wr(2'd3, 32'hABCD_0004);
    rd("period_trunc", 2'd3, 32'h4);
    address = 2'd0;
    in_port[0] = 1'b0;                       // just after edge 0
    repeat (7) tick();                       // edge 7: db falls here
    chk("press0_before", readdata, 32'h3);   // readdata shows db before edge 7
    tick();                                  // edge 8
    chk("press0_after", readdata, 32'h2);
    rd("press0_edge", 2'd2, 32'h1);
    chk("press0_irq_masked", {31'b0, irq}, 32'h0);

    // 3. 3-clock glitch on key1 is rejected; DATA write ignored
    address = 2'd0;
    in_port[1] = 1'b0;
    repeat (3) tick();
    in_port[1] = 1'b1;
    repeat (12) tick();
    chk("glitch_data", readdata, 32'h2);
    rd("glitch_edge", 2'd2, 32'h1);
    wr(2'd0, 32'hFFFF_FFFF);
    rd("data_ro", 2'd0, 32'h2);

    // 4. masked interrupt on key0 press, cleared by W1C
    wr(2'd2, 32'h1);
    rd("edge_cleared", 2'd2, 32'h0);
    in_port[0] = 1'b1;                       // release: must not set EDGE
    repeat (12) tick();
    rd("release_no_edge", 2'd2, 32'h0);
    rd("release_data", 2'd0, 32'h3);
    wr(2'd1, 32'hFFFF_FFFD);                 // only MASK[1:0] kept -> 0x1
    rd("mask_rd", 2'd1, 32'h1);
    address = 2'd2;
    in_port[0] = 1'b0;                       // edge 0
    repeat (7) tick();                       // edge 7: EDGE[0] sets
    chk("irq_lag_lo", {31'b0, irq}, 32'h0);
    chk("edge_lag", readdata, 32'h0);
    tick();                                  // edge 8
    chk("irq_hi", {31'b0, irq}, 32'h1);
    chk("edge_set", readdata, 32'h1);
    wr(2'd2, 32'h1);                         // EDGE clears at this edge
    chk("irq_hold", {31'b0, irq}, 32'h1);
    tick();
    chk("irq_clr", {31'b0, irq}, 32'h0);
    chk("edge_w1c", readdata, 32'h0);

    // 5. W1C of EDGE[1] on the same edge as key1 press: set wins
    address = 2'd2;
    in_port[1] = 1'b0;                       // edge 0
    repeat (6) tick();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h2;
    tick();                                  // edge 7: press and W1C together
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick();
    chk("set_wins", readdata, 32'h2);
    chk("set_wins_irq", {31'b0, irq}, 32'h0);

    // 6. reset mid-settle with EDGE=3, MASK=3
    in_port[0] = 1'b1;
    repeat (12) tick();
    in_port[0] = 1'b0;
    repeat (12) tick();
    wr(2'd1, 32'h3);
    rd("pre_rst_edge", 2'd2, 32'h3);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    in_port[1] = 1'b1;                       // key1 release starts settling
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_readdata", readdata, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    tick();
    reset_n = 1'b1;                          // just after edge R
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h4;
    tick();                                  // edge R+1
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    chk("rd_old_on_write", readdata, 32'd50000);
    address = 2'd0;
    tick();                                  // edge R+2
    chk("post_rst_data", readdata, 32'h3);
    repeat (5) tick();                       // edge R+7: db0 falls
    chk("redeb_before", readdata, 32'h3);
    tick();                                  // edge R+8
    chk("redeb_after", readdata, 32'h2);
    rd("post_rst_edge", 2'd2, 32'h1);
    rd("post_rst_mask", 2'd1, 32'h0);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
